// File: rtl/if_prefetch_pkg.sv
// Shared constants for the if_prefetch fetch unit: bus width, NOP encoding,
// reset PC default and the PC step between sequential fetches.
// Also provides the counter width helper used for the in-flight/discard/fill counters.
package if_prefetch_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] INST_NOP_DEF = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned PC_INC       = 4;

  // Counters must hold the value DEPTH itself, hence one bit above log2.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_prefetch_fetch_fifo.sv
// Purpose: synchronous DEPTH x WIDTH FIFO with push/pop/flush, occupancy count, full/empty.
// Latency: a push becomes visible at head_dat the cycle after it is written (no bypass).
// Backpressure: push while full is accepted only together with a pop; flush drops everything and wins over push/pop.
// Ports: clk, rstn (async active-low); push/push_dat write side; pop read side;
//        flush clears; head_dat is the oldest entry; count/full/empty status.
module if_prefetch_fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty & ~flush;
  // When full and popping, the slot being written is the one being read out this cycle.
  assign do_push  = push & ~flush & (~full | do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_prefetch.sv
// Purpose: instruction-fetch unit; owns the PC, issues pipelined req/gnt fetches, buffers {pc, word} for decode.
// Latency: gnt in cycle N, rvalid in N+1 at the earliest -> inst_valid in N+2.
// Backpressure: requests issue only while in-flight + buffered < DEPTH, so a full buffer stalls mem_req.
// Ports: clk, rstn (async active-low); redirect_valid/redirect_pc restart fetch;
//        mem_req/mem_addr/mem_gnt/mem_rvalid/mem_rdata instruction-memory port;
//        inst_valid/inst/inst_pc/inst_ready decode handshake (inst = INST_NOP while !inst_valid).
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEF,
  parameter int unsigned      DEPTH    = 2,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF),
  parameter logic [XLEN-1:0]  INST_NOP = XLEN'(INST_NOP_DEF)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);

  localparam int unsigned CW      = cnt_w(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } fetch_ent_t;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] ret_pc;       // PC of the next response that will be kept
  logic [CW-1:0]   outstanding;  // granted, response not yet returned
  logic [CW-1:0]   discard;      // of the outstanding ones, how many belong to a flushed stream
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] redir_pc_al;
  logic            grant;
  logic            drop;
  logic            push;
  logic            pop;
  fetch_ent_t      push_ent;
  fetch_ent_t      head_ent;

  assign redir_pc_al = redirect_pc & ~XLEN'(3);
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};

  // Gating with rstn keeps the port quiet while reset is held, not only after the first edge.
  assign mem_req  = rstn & ~redirect_valid & (credit_used < DEPTH_C);
  assign mem_addr = pc;
  assign grant    = mem_req & mem_gnt;

  // A response landing in the redirect cycle belongs to the old stream and is dropped directly.
  assign drop     = mem_rvalid & ((discard != '0) | redirect_valid);
  assign push     = mem_rvalid & ~drop;
  assign push_ent = '{pc: ret_pc, word: mem_rdata};

  assign inst_valid = ~fifo_empty;
  assign pop        = inst_valid & inst_ready & ~redirect_valid;
  assign inst       = inst_valid ? head_ent.word : INST_NOP;
  assign inst_pc    = inst_valid ? head_ent.pc   : ret_pc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc          <= RESET_PC;
      ret_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(mem_rvalid);
      if (redirect_valid) begin
        pc      <= redir_pc_al;
        ret_pc  <= redir_pc_al;
        // Everything still in flight after this cycle belongs to the abandoned stream.
        discard <= outstanding - CW'(mem_rvalid);
      end else begin
        if (grant) pc     <= pc + XLEN'(PC_INC);
        if (push)  ret_pc <= ret_pc + XLEN'(PC_INC);
        if (mem_rvalid && (discard != '0)) discard <= discard - 1'b1;
      end
    end
  end

  if_prefetch_fetch_fifo #(
    .WIDTH ($bits(fetch_ent_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .flush    (redirect_valid),
    .head_dat (head_ent),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assert property (@(posedge clk) disable iff (!rstn) outstanding <= CW'(DEPTH));
  assert property (@(posedge clk) disable iff (!rstn) discard <= CW'(DEPTH));
  assert property (@(posedge clk) disable iff (!rstn) mem_rvalid |-> (outstanding != '0));
  assert property (@(posedge clk) disable iff (!rstn) push |-> (!fifo_full || pop));

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: random memory timing, random decode stalls and random redirects,
// checked against a stream model (every grant since the last redirect/reset delivered in order).
module tb_if_prefetch;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  always #5 clk = ~clk;

  if_prefetch #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC),
    .INST_NOP (NOP)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  int n_cmp = 0;
  int n_err = 0;
  int unsigned gnt_pct = 0;
  int unsigned rv_pct  = 0;
  int unsigned rdy_pct = 0;

  typedef struct { logic [31:0] addr; int epoch; } pend_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] word; } exp_t;

  pend_t       pend_q[$];   // requests the memory owes a response for
  exp_t        exp_q[$];    // words decode should still receive, oldest first
  logic [31:0] fpc = RST_PC;
  int          epoch = 0;
  int          grant_cnt = 0;
  logic        redir_prev = 1'b0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'hC0DE_5A11;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  // Memory and decode-ready driver: inputs change 1 time unit after the rising edge.
  always begin
    @(posedge clk);
    #1;
    if (!rstn) begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      inst_ready = 1'b0;
    end else begin
      mem_gnt    = ($urandom_range(99) < gnt_pct);
      inst_ready = ($urandom_range(99) < rdy_pct);
      if (pend_q.size() > 0 && $urandom_range(99) < rv_pct) begin
        mem_rvalid = 1'b1;
        mem_rdata  = memf(pend_q[0].addr);
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end
    end
  end

  // Monitor / scoreboard: one pass per cycle on the falling edge.
  always @(negedge clk) begin
    int stale;
    stale = 0;
    if (!rstn) begin
      pend_q.delete();
      exp_q.delete();
      fpc        = RST_PC;
      epoch      = epoch + 1;
      redir_prev = 1'b0;
    end else begin
      foreach (pend_q[i]) if (pend_q[i].epoch != epoch) stale++;
      // Every live fetch (current stream, not yet consumed) plus every stale one in flight uses a credit.
      chk1("mem_req", mem_req, !redirect_valid && (exp_q.size() + stale < DEPTH));
      if (redir_prev) chk1("valid_after_redirect", inst_valid, 1'b0);
      if (!inst_valid) chk("nop_when_empty", inst, NOP);
      if (inst_valid && inst_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          chk1("pop_with_nothing_expected", inst_valid, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pop_pc", inst_pc, e.pc);
          chk("pop_inst", inst, e.word);
        end
      end
      if (mem_rvalid && pend_q.size() > 0) void'(pend_q.pop_front());
      if (mem_req && mem_gnt) begin
        chk("mem_addr", mem_addr, fpc);
        pend_q.push_back('{addr: mem_addr, epoch: epoch});
        exp_q.push_back('{pc: fpc, word: memf(fpc)});
        fpc       = fpc + 32'd4;
        grant_cnt = grant_cnt + 1;
      end
      if (redirect_valid) begin
        epoch = epoch + 1;
        exp_q.delete();
        fpc = redirect_pc & 32'hFFFF_FFFC;
      end
      redir_prev = redirect_valid;
    end
  end

  initial begin
    int          g;
    int          v;
    int          bad;
    int          g0;
    logic        found;
    logic [31:0] fp_pc;
    logic [31:0] fp_inst;
    logic [31:0] prev_addr;
    logic [31:0] wrap_got;

    // Reset state
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, NOP);
    chk("rst_inst_pc", inst_pc, RST_PC);
    chk1("rst_mem_req", mem_req, 1'b0);

    // Streaming from reset: first word two cycles after first grant, then one per cycle
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    @(posedge clk); #1 rstn = 1'b1;
    g = -1; v = -1;
    for (int c = 0; c < 20 && v < 0; c++) begin
      @(negedge clk);
      if (g < 0 && mem_req && mem_gnt) g = c;
      if (v < 0 && inst_valid) v = c;
    end
    chk("first_valid_latency", v, g + 2);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (!inst_valid) bad++;
    end
    chk("stream_gap_cycles", bad, 0);

    // Decode stalled: exactly DEPTH new requests, then mem_req stays low
    @(negedge clk); rdy_pct = 0;
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    @(posedge clk); #1 redirect_valid = 1'b0; g0 = grant_cnt;
    repeat (12) @(posedge clk);
    #1;
    chk("grants_while_stalled", grant_cnt - g0, DEPTH);
    chk1("req_low_when_full", mem_req, 1'b0);
    @(negedge clk); rdy_pct = 100;
    repeat (12) @(posedge clk);

    // Redirect with requests in flight: late responses dropped, restart at 0x100
    @(negedge clk); rv_pct = 0;
    repeat (8) @(posedge clk);
    #1 redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk); rv_pct = 100;
    @(posedge clk); #1 redirect_valid = 1'b0;
    found = 1'b0; fp_pc = 32'hDEAD_DEAD; fp_inst = 32'hDEAD_DEAD;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        fp_pc = inst_pc; fp_inst = inst; found = 1'b1;
      end
    end
    chk("redirect_first_pc", fp_pc, 32'h0000_0100);
    chk("redirect_first_inst", fp_inst, memf(32'h0000_0100));

    // Redirects on top of a full-rate stream (coincident rvalid + ready), back to back
    repeat (5) @(posedge clk);
    #1 redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    @(posedge clk); #1 redirect_pc = 32'h0000_0403;
    @(posedge clk); #1 redirect_valid = 1'b0;
    repeat (15) @(posedge clk);

    // PC wrap at the top of the address space
    #1 redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF6;
    @(posedge clk); #1 redirect_valid = 1'b0;
    found = 1'b0; prev_addr = '0; wrap_got = 32'hBAD0_BAD0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (mem_req && mem_gnt) begin
        if (prev_addr == 32'hFFFF_FFFC) begin
          wrap_got = mem_addr; found = 1'b1;
        end
        prev_addr = mem_addr;
      end
    end
    chk("wrap_addr", wrap_got, 32'h0000_0000);

    // Reset asserted mid-stream: outputs drop immediately
    repeat (4) @(negedge clk);
    chk1("pre_reset_valid", inst_valid, 1'b1);
    @(posedge clk); #1 rstn = 1'b0;
    #1;
    chk1("midrst_inst_valid", inst_valid, 1'b0);
    chk("midrst_inst", inst, NOP);
    chk1("midrst_mem_req", mem_req, 1'b0);
    chk("midrst_inst_pc", inst_pc, RST_PC);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (10) @(posedge clk);

    // Random traffic with random redirects
    for (int blk = 0; blk < 60; blk++) begin
      @(negedge clk);
      gnt_pct = $urandom_range(100);
      rv_pct  = $urandom_range(100);
      rdy_pct = $urandom_range(100);
      for (int c = 0; c < 50; c++) begin
        @(posedge clk);
        #1;
        if ($urandom_range(99) < 4) begin
          redirect_valid = 1'b1;
          redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
        end else begin
          redirect_valid = 1'b0;
        end
      end
    end
    @(posedge clk); #1 redirect_valid = 1'b0;

    // Drain: every fetched word of the current stream must come out
    @(negedge clk); gnt_pct = 0; rv_pct = 100; rdy_pct = 100;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk);
    chk("drain_remaining", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
